// File: rtl/muldiv_sequencer_pkg.sv
// muldiv_sequencer_pkg: state, op and DIVM phase encodings shared with control_unit and the DIVM handler
package muldiv_sequencer_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_LDA, S_LDB, S_MRUN, S_DRUN, S_WB, S_EXC
  } state_t;
  typedef enum logic [1:0] {
    OP_MULT = 2'b00,
    OP_DIV  = 2'b01,
    OP_DIVM = 2'b10,
    OP_RSVD = 2'b11
  } op_t;
  typedef enum logic [2:0] {
    DM_NONE = 3'd0,
    DM_LDA  = 3'd1,
    DM_LDB  = 3'd2,
    DM_RUN  = 3'd3
  } divm_t;
endpackage

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: sequences multiplier/divider runs, HI/LO write-back, timeout and divide-by-zero aborts
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W       = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] op,
  input  logic       mult_end,
  input  logic       div_done,
  input  logic       div_by0,
  output logic       mult_control,
  output logic       mult_rst,
  output logic       div_op,
  output logic       div_rst,
  output logic [2:0] divm_op,
  output logic       hilo_src,
  output logic       hi_w,
  output logic       lo_w,
  output logic       busy,
  output logic       done,
  output logic       exc_divby0,
  output logic       exc_timeout
);
  state_t            state, state_nx;
  op_t               op_q;
  logic [CNT_W-1:0]  cnt;
  logic              to_q;
  logic              run;
  logic              expired;
  logic              clr_ph;
  assign run     = state == S_MRUN || state == S_DRUN;
  assign expired = cnt == CNT_W'(TIMEOUT_CYC - 1);
  assign clr_ph  = state == S_CLR || state == S_EXC;
  // State, latched op, run counter and abort cause; to_q remembers whether an abort was a timeout
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      op_q  <= OP_MULT;
      cnt   <= '0;
      to_q  <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && start && op != OP_RSVD) op_q <= op_t'(op);
      if (state == S_CLR) cnt <= '0;
      else if (run) cnt <= cnt + 1'b1;
      if (run) to_q <= state == S_MRUN || !div_by0;
    end
  end
  // Next state; completion wins over an expiring counter, div_by0 wins over div_done
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  state_nx = (start && op != OP_RSVD) ? S_CLR : S_IDLE;
      S_CLR:   state_nx = op_q == OP_MULT ? S_MRUN : op_q == OP_DIV ? S_DRUN : S_LDA;
      S_LDA:   state_nx = S_LDB;
      S_LDB:   state_nx = S_DRUN;
      S_MRUN:  state_nx = mult_end ? S_WB : expired ? S_EXC : S_MRUN;
      S_DRUN:  state_nx = div_by0 ? S_EXC : div_done ? S_WB : expired ? S_EXC : S_DRUN;
      default: state_nx = S_IDLE;
    endcase
  end
  assign mult_control = state == S_MRUN;
  assign mult_rst     = clr_ph && op_q == OP_MULT;
  assign div_op       = state == S_DRUN;
  assign div_rst      = clr_ph && op_q != OP_MULT;
  assign divm_op      = state == S_LDA ? DM_LDA :
                        state == S_LDB ? DM_LDB :
                        (state == S_DRUN && op_q == OP_DIVM) ? DM_RUN : DM_NONE;
  assign hilo_src     = state == S_DRUN || (state == S_WB && op_q != OP_MULT);
  assign hi_w         = state == S_WB;
  assign lo_w         = state == S_WB;
  assign done         = state == S_WB;
  assign busy         = state != S_IDLE;
  assign exc_divby0   = state == S_EXC && !to_q;
  assign exc_timeout  = state == S_EXC && to_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed scenarios plus randomized traffic checked against a transaction-level model
module tb_muldiv_sequencer;
  localparam int TO = 64;
  logic clk = 0, reset = 1, start = 0, mult_end = 0, div_done = 0, div_by0 = 0;
  logic [1:0] op = 0;
  logic mult_control, mult_rst, div_op, div_rst, hilo_src, hi_w, lo_w, busy, done;
  logic exc_divby0, exc_timeout;
  logic [2:0] divm_op;
  logic [13:0] outv;
  int checks = 0, failures = 0;
  muldiv_sequencer #(.TIMEOUT_CYC(TO), .CNT_W(7)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .mult_end(mult_end),
    .div_done(div_done), .div_by0(div_by0), .mult_control(mult_control),
    .mult_rst(mult_rst), .div_op(div_op), .div_rst(div_rst), .divm_op(divm_op),
    .hilo_src(hilo_src), .hi_w(hi_w), .lo_w(lo_w), .busy(busy), .done(done),
    .exc_divby0(exc_divby0), .exc_timeout(exc_timeout)
  );
  always #5 clk = ~clk;
  assign outv = {mult_control, mult_rst, div_op, div_rst, divm_op, hilo_src,
                 hi_w, lo_w, busy, done, exc_divby0, exc_timeout};
  // model: age = cycles since a request was accepted (0 = idle), runs = run cycles spent,
  // outcome = 0 still working, 1 write-back, 2 divide-by-zero, 3 timeout
  int age = 0, runs = 0, outcome = 0;
  logic [1:0] mop = 0;
  function automatic int first_run(logic [1:0] o);
    return o == 2'd2 ? 4 : 2;
  endfunction
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      age <= 0; runs <= 0; outcome <= 0; mop <= 0;
    end else if (age == 0) begin
      if (start && op != 2'd3) begin
        age <= 1; mop <= op; runs <= 0; outcome <= 0;
      end
    end else if (outcome != 0) begin
      age <= 0;
    end else if (age >= first_run(mop)) begin
      runs <= runs + 1;
      if (mop != 0 && div_by0) outcome <= 2;
      else if (mop == 0 ? mult_end : div_done) outcome <= 1;
      else if (runs + 1 == TO) outcome <= 3;
    end else begin
      age <= age + 1;
    end
  end
  function automatic logic [13:0] model_out();
    logic mc = 0, mr = 0, dop = 0, dr = 0, hs = 0, hw = 0, bz = 0, dn = 0, ed = 0, et = 0;
    logic [2:0] dm = 0;
    if (age != 0) begin
      bz = 1;
      if (outcome == 1) begin
        hw = 1; dn = 1; hs = mop != 0;
      end else if (outcome >= 2) begin
        ed = outcome == 2; et = outcome == 3; mr = mop == 0; dr = mop != 0;
      end else if (age == 1) begin
        mr = mop == 0; dr = mop != 0;
      end else if (age < first_run(mop)) begin
        dm = age == 2 ? 3'd1 : 3'd2;
      end else if (mop == 0) begin
        mc = 1;
      end else begin
        dop = 1; hs = 1; dm = mop == 2 ? 3'd3 : 3'd0;
      end
    end
    return {mc, mr, dop, dr, dm, hs, hw, hw, bz, dn, ed, et};
  endfunction
  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask
  always @(negedge clk) chk("model_outputs", 32'(outv), 32'(model_out()));
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic timeout_run(bit late);
    int n_exc = 0;
    start = 1; op = 0;
    tick(); start = 0;
    for (int c = 2; c <= 65; c++) begin
      tick();
      n_exc += int'(exc_timeout);
      if (late && c == 65) mult_end = 1;
    end
    tick(); mult_end = 0;
    chk("to_no_early_exc", n_exc, 0);
    chk("to_exc_timeout", exc_timeout, !late);
    chk("to_mult_rst", mult_rst, !late);
    chk("to_done", done, late);
    tick();
    chk("to_idle", busy, 0);
  endtask
  initial begin
    #1 reset = 0;
    #1 chk("reset_outputs", outv, 0);
    tick(); reset = 1;
    // MULT, with an ignored DIV request mid-run
    start = 1; op = 0;
    tick(); start = 0;
    chk("mult_clr", {mult_rst, mult_control, div_rst}, 3'b100);
    for (int c = 2; c <= 10; c++) begin
      tick();
      chk("mult_run", mult_control, 1);
      start = c == 5; op = c == 5 ? 2'd1 : 2'd0;
      mult_end = c == 10;
    end
    tick(); mult_end = 0; start = 0;
    chk("mult_wb", {hi_w, lo_w, done, hilo_src}, 4'b1110);
    tick();
    chk("mult_idle", {busy, done}, 2'b00);
    // DIVM phases
    start = 1; op = 2;
    tick(); start = 0;
    for (int c = 2; c <= 8; c++) begin
      tick();
      chk("divm_phase", divm_op, c == 2 ? 1 : c == 3 ? 2 : 3);
      div_done = c == 8;
    end
    tick(); div_done = 0;
    chk("divm_wb", {hi_w, lo_w, done, hilo_src}, 4'b1111);
    tick();
    // DIV with divide-by-zero racing div_done
    start = 1; op = 1;
    tick(); start = 0;
    tick();
    tick(); div_by0 = 1; div_done = 1;
    tick(); div_by0 = 0; div_done = 0;
    chk("div0_exc", {exc_divby0, exc_timeout, div_rst, mult_rst}, 4'b1010);
    chk("div0_nowb", {hi_w, lo_w, done}, 3'b000);
    tick();
    chk("div0_idle", busy, 0);
    timeout_run(0);
    timeout_run(1);
    // async reset in the 5th MRUN cycle
    start = 1; op = 0;
    tick(); start = 0;
    for (int c = 2; c <= 6; c++) tick();
    chk("rst_pre_run", mult_control, 1);
    #1 reset = 0;
    #1 chk("rst_async_outputs", outv, 0);
    mult_end = 1;
    tick(); tick(); reset = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_no_wb", {done, busy}, 2'b00);
    end
    mult_end = 0;
    // reserved op is not accepted
    start = 1; op = 3;
    tick(); start = 0;
    chk("rsvd_busy", busy, 0);
    tick();
    chk("rsvd_outputs", outv, 0);
    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      start = $urandom_range(0, 3) == 0;
      op = 2'($urandom_range(0, 3));
      mult_end = $urandom_range(0, 29) == 0;
      div_done = $urandom_range(0, 29) == 0;
      div_by0 = $urandom_range(0, 79) == 0;
      if ($urandom_range(0, 299) == 0) begin
        reset = 0;
        #1 chk("rand_async_rst", outv, 0);
        tick(); reset = 1;
      end else begin
        tick();
      end
    end
    start = 0; mult_end = 0; div_done = 0; div_by0 = 0;
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
